// File: rtl/pattern_buffer.sv
// pattern_buffer: a ring of NBUF buffers, each NFIELD fields of BUFFER_WIDTH bits.
// Each buffer is filled from a valid/ready stream, handed to a processor for
// random-access read/modify, then drained to an output stream in index order.
// Optional feature macro: PATBUF_CLEAR_ON_DRAIN_EN zeroes each field as it drains.
module pattern_buffer #(
    parameter int BUFP_WIDTH   = 3,
    parameter int FIELDP_WIDTH = 5,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    // processor side
    input  logic [BUFP_WIDTH-1:0]   bufp,
    input  logic [FIELDP_WIDTH-1:0] fieldp,
    input  logic [FIELDP_WIDTH-1:0] fieldwp,
    input  logic                    write_en,
    input  logic [BUFFER_WIDTH-1:0] field_out,
    output logic [BUFFER_WIDTH-1:0] field_in,
    input  logic                    proc_done,
    output logic                    buf_ready,
    // fill stream
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [BUFFER_WIDTH-1:0] in_data,
    // drain stream
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [BUFFER_WIDTH-1:0] out_data
);

    localparam int NBUF   = 2**BUFP_WIDTH;
    localparam int NFIELD = 2**FIELDP_WIDTH;

`ifdef PATBUF_CLEAR_ON_DRAIN_EN
    localparam bit CLEAR_ON_DRAIN = 1'b1;
`else
    localparam bit CLEAR_ON_DRAIN = 1'b0;
`endif

    // Lifecycle of one buffer; fill, processor and drain each own a distinct
    // subset of these states, which is what keeps their targets disjoint.
    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DONE,
        ST_DRAINING
    } buf_state_e;

    buf_state_e              state_q [NBUF];
    buf_state_e              state_d [NBUF];

    logic [BUFFER_WIDTH-1:0] mem [NBUF][NFIELD];
    // Length is kept as the index of the last field (len-1), so 1..NFIELD
    // fits in FIELDP_WIDTH bits and out_last is a plain equality.
    logic [FIELDP_WIDTH-1:0] last_idx [NBUF];

    logic [BUFP_WIDTH-1:0]   fill_buf;
    logic [FIELDP_WIDTH-1:0] fill_idx;
    logic [BUFP_WIDTH-1:0]   drain_buf;
    logic [FIELDP_WIDTH-1:0] drain_idx;
    logic                    out_valid_q;

    logic fill_fire;
    logic fill_end;
    logic proc_write;
    logic proc_release;
    logic drain_start;
    logic drain_fire;
    logic drain_end;

    // Status and data outputs, all decoded from registered state.
    assign in_ready  = (state_q[fill_buf] == ST_EMPTY) || (state_q[fill_buf] == ST_FILLING);
    assign buf_ready = (state_q[bufp] == ST_FULL);
    assign field_in  = mem[bufp][fieldp];
    assign out_valid = out_valid_q;
    assign out_data  = mem[drain_buf][drain_idx];
    assign out_last  = (drain_idx == last_idx[drain_buf]);

    // Events for this cycle; a cycle with reset asserted performs none of them,
    // so a transfer that coincides with reset is discarded.
    assign fill_fire    = !reset && in_valid && in_ready;
    assign fill_end     = fill_fire && (in_last || (fill_idx == '1));
    assign proc_write   = !reset && write_en && buf_ready;
    assign proc_release = !reset && proc_done && buf_ready;
    assign drain_fire   = !reset && out_valid_q && out_ready;
    assign drain_end    = drain_fire && out_last;
    assign drain_start  = !reset && !out_valid_q && (state_q[drain_buf] == ST_DONE);

    // Next-state for every buffer: each event only touches the buffer it owns.
    always_comb begin
        // NOTE: default every output of a combinational block first so no path
        // leaves it unassigned and a latch is never inferred.
        state_d = state_q;
        if (fill_fire) begin
            state_d[fill_buf] = fill_end ? ST_FULL : ST_FILLING;
        end
        if (proc_release) begin
            state_d[bufp] = ST_DONE;
        end
        if (drain_start) begin
            state_d[drain_buf] = ST_DRAINING;
        end
        if (drain_end) begin
            state_d[drain_buf] = ST_EMPTY;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBUF; b++) begin
                state_q[b] <= ST_EMPTY;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    // Fill and drain pointers plus the registered out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_buf    <= '0;
            fill_idx    <= '0;
            drain_buf   <= '0;
            drain_idx   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fill_end) begin
                fill_idx <= '0;
                fill_buf <= fill_buf + BUFP_WIDTH'(1);
            end else if (fill_fire) begin
                fill_idx <= fill_idx + FIELDP_WIDTH'(1);
            end

            // After the last handshake out_valid stays low for at least one
            // cycle, since drain_start requires out_valid_q to be low.
            if (drain_end) begin
                drain_idx   <= '0;
                drain_buf   <= drain_buf + BUFP_WIDTH'(1);
                out_valid_q <= 1'b0;
            end else if (drain_fire) begin
                drain_idx <= drain_idx + FIELDP_WIDTH'(1);
            end else if (drain_start) begin
                out_valid_q <= 1'b1;
            end
        end
    end

    // Field storage and per-buffer length; up to three writes per cycle, each
    // to a different buffer because their owning states never coincide.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset; contents are only
        // meaningful after a fill, and a reset on a RAM blocks memory inference.
        if (fill_fire) begin
            mem[fill_buf][fill_idx] <= in_data;
        end
        if (fill_end) begin
            last_idx[fill_buf] <= fill_idx;
        end
        if (proc_write) begin
            mem[bufp][fieldwp] <= field_out;
        end
        if (CLEAR_ON_DRAIN && drain_fire) begin
            mem[drain_buf][drain_idx] <= '0;
        end
    end

endmodule

// File: tb/tb_pattern_buffer.sv
// Self-checking bench for pattern_buffer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the buffer lifecycle.
module tb_pattern_buffer;

    localparam int NBUF   = 8;
    localparam int NFIELD = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [4:0] fieldwp;
    logic       write_en;
    logic [7:0] field_out;
    logic [7:0] field_in;
    logic       proc_done;
    logic       buf_ready;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    pattern_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .bufp      (bufp),
        .fieldp    (fieldp),
        .fieldwp   (fieldwp),
        .write_en  (write_en),
        .field_out (field_out),
        .field_in  (field_in),
        .proc_done (proc_done),
        .buf_ready (buf_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_data  (out_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

`ifdef PATBUF_CLEAR_ON_DRAIN_EN
    localparam bit CLEARS = 1'b1;
`else
    localparam bit CLEARS = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    typedef enum int {M_EMPTY, M_FILLING, M_FULL, M_DONE, M_DRAINING} mstate_e;

    mstate_e    m_st    [NBUF];
    int         m_len   [NBUF];
    logic [7:0] m_mem   [NBUF][NFIELD];
    bit         m_known [NBUF][NFIELD];
    int         m_fb, m_fi, m_db, m_di;
    bit         m_ov;
    bit         rst_seen = 1'b0;

    // Handshakes actually observed on the drain port.
    logic [7:0] got_data[$];
    logic       got_last[$];

    // Advance the model across one rising edge using the inputs applied to it.
    function automatic void model_edge();
        mstate_e old [NBUF];
        bit      rdy;
        if (reset) begin
            foreach (m_st[b]) m_st[b] = M_EMPTY;
            m_fb = 0; m_fi = 0; m_db = 0; m_di = 0; m_ov = 1'b0;
            rst_seen = 1'b1;
            return;
        end
        old = m_st;
        rdy = (old[m_fb] == M_EMPTY) || (old[m_fb] == M_FILLING);
        if (old[bufp] == M_FULL) begin
            if (write_en) begin
                m_mem[bufp][fieldwp]   = field_out;
                m_known[bufp][fieldwp] = 1'b1;
            end
            if (proc_done) m_st[bufp] = M_DONE;
        end
        if (in_valid && rdy) begin
            m_mem[m_fb][m_fi]   = in_data;
            m_known[m_fb][m_fi] = 1'b1;
            m_st[m_fb]          = M_FILLING;
            if (in_last || m_fi == NFIELD - 1) begin
                m_len[m_fb] = m_fi + 1;
                m_st[m_fb]  = M_FULL;
                m_fi        = 0;
                m_fb        = (m_fb + 1) % NBUF;
            end else begin
                m_fi++;
            end
        end
        if (m_ov && out_ready) begin
            if (CLEARS) m_mem[m_db][m_di] = 8'h00;
            if (m_di == m_len[m_db] - 1) begin
                m_st[m_db] = M_EMPTY;
                m_di       = 0;
                m_db       = (m_db + 1) % NBUF;
                m_ov       = 1'b0;
            end else begin
                m_di++;
            end
        end else if (!m_ov && old[m_db] == M_DONE) begin
            m_ov       = 1'b1;
            m_st[m_db] = M_DRAINING;
        end
    endfunction

    // Single compare process: outputs checked mid-cycle, then the model steps.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("in_ready", 32'(in_ready),
                  32'((m_st[m_fb] == M_EMPTY) || (m_st[m_fb] == M_FILLING)));
            check("buf_ready", 32'(buf_ready), 32'(m_st[bufp] == M_FULL));
            if (m_known[bufp][fieldp])
                check("field_in", 32'(field_in), 32'(m_mem[bufp][fieldp]));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                check("out_data", 32'(out_data), 32'(m_mem[m_db][m_di]));
                check("out_last", 32'(out_last), 32'(m_di == m_len[m_db] - 1));
            end
        end
        if (!reset && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        model_edge();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0; write_en = 1'b0; proc_done = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int k = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && k < 200) begin step(); k++; end
        if (k == 200) check("send timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_drained(input int n, input int budget);
        int k = 0;
        while (got_data.size() < n && k < budget) begin step(); k++; end
        if (got_data.size() < n) check("drain timeout", 32'd0, 32'd1);
    endtask

    task automatic release_buf(input logic [2:0] b);
        bufp = b; proc_done = 1'b1;
        step();
        proc_done = 1'b0;
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int k;
        logic [7:0] exp4 [4];
        exp4[0] = 8'h11; exp4[1] = 8'hA5; exp4[2] = 8'h33; exp4[3] = 8'h44;

        bufp = '0; fieldp = '0; fieldwp = '0; field_out = '0; in_data = '0; in_last = 1'b0;
        do_reset();
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst buf_ready", 32'(buf_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);

        // Fill buffer 0 with four bytes, last on the fourth.
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        bufp = 3'd0; fieldp = 5'd2;
        #1;
        check("fill0 field_in", 32'(field_in), 32'h33);
        check("fill0 buf_ready", 32'(buf_ready), 32'd1);
        check("fill0 in_ready", 32'(in_ready), 32'd1);

        // Processor patches field 1, releases, buffer drains.
        fieldwp = 5'd1; field_out = 8'hA5; write_en = 1'b1;
        step();
        write_en = 1'b0;
        got_data.delete(); got_last.delete();
        release_buf(3'd0);
        out_ready = 1'b1;
        wait_drained(4, 40);
        check("drain0 count", 32'(got_data.size()), 32'd4);
        if (got_data.size() == 4) begin
            for (int i = 0; i < 4; i++) check("drain0 data", 32'(got_data[i]), 32'(exp4[i]));
            check("drain0 mid last", 32'(got_last[2]), 32'd0);
            check("drain0 last", 32'(got_last[3]), 32'd1);
        end
        step();
        fieldp = 5'd1;
        #1;
        check("post-drain field1", 32'(field_in), CLEARS ? 32'h00 : 32'hA5);

        // Write and release aimed at an EMPTY buffer must do nothing.
        bufp = 3'd0; fieldwp = 5'd2; field_out = 8'h5A; write_en = 1'b1; proc_done = 1'b1;
        step();
        write_en = 1'b0; proc_done = 1'b0; fieldp = 5'd2;
        #1;
        check("empty write ignored", 32'(field_in), CLEARS ? 32'h00 : 32'h33);
        check("empty release ignored", 32'(buf_ready), 32'd0);
        out_ready = 1'b0;

        // 32 bytes with no in_last auto-terminate buffer 1.
        for (int i = 0; i < NFIELD; i++) send(8'(8'h80 + i), 1'b0);
        bufp = 3'd1; fieldp = 5'd31;
        #1;
        check("auto-term buf_ready", 32'(buf_ready), 32'd1);
        check("auto-term field31", 32'(field_in), 32'h9F);
        check("auto-term in_ready", 32'(in_ready), 32'd1);

        // Drain with a 5-cycle stall on the first field.
        got_data.delete(); got_last.delete();
        release_buf(3'd1);
        k = 0;
        while (!out_valid && k < 20) begin step(); k++; end
        if (!out_valid) check("out_valid timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall data", 32'(out_data), 32'h80);
            check("stall last", 32'(out_last), 32'd0);
            step();
        end
        out_ready = 1'b1;
        wait_drained(32, 100);
        check("drain1 count", 32'(got_data.size()), 32'd32);
        if (got_data.size() == 32) begin
            check("drain1 final data", 32'(got_data[31]), 32'h9F);
            check("drain1 final last", 32'(got_last[31]), 32'd1);
        end

        // Fill all buffers, then free buffer 0 and watch the fill pointer wrap.
        do_reset();
        for (int b = 0; b < NBUF; b++)
            for (int i = 0; i <= b * 4; i++) send(8'(b * 16 + i), (i == b * 4));
        #1;
        check("all full in_ready", 32'(in_ready), 32'd0);
        got_data.delete(); got_last.delete();
        release_buf(3'd0);
        out_ready = 1'b1;
        wait_drained(1, 20);
        #1;
        check("freed in_ready", 32'(in_ready), 32'd1);
        send(8'hEE, 1'b1);
        bufp = 3'd0; fieldp = 5'd0;
        #1;
        check("wrap buf_ready", 32'(buf_ready), 32'd1);
        check("wrap field_in", 32'(field_in), 32'hEE);
        check("wrap in_ready", 32'(in_ready), 32'd0);

        // Randomized traffic on every port.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            in_data   = 8'($urandom);
            bufp      = 3'($urandom_range(0, 7));
            fieldp    = 5'($urandom_range(0, 31));
            fieldwp   = 5'($urandom_range(0, 31));
            write_en  = 1'($urandom_range(0, 1));
            field_out = 8'($urandom);
            proc_done = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; write_en = 1'b0; proc_done = 1'b0; reset = 1'b0;

        // Reset in the middle of a drain, with drain_idx at 2.
        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), (i == 5));
        got_data.delete(); got_last.delete();
        release_buf(3'd0);
        out_ready = 1'b1;
        wait_drained(2, 20);
        reset = 1'b1; out_ready = 1'b0; bufp = 3'd0;
        step();
        #1;
        check("mid-drain rst out_valid", 32'(out_valid), 32'd0);
        check("mid-drain rst in_ready", 32'(in_ready), 32'd1);
        check("mid-drain rst buf_ready", 32'(buf_ready), 32'd0);
        reset = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_buffer.md
PATTERN_BUFFER -- requirements
Module: pattern_buffer

Interface
REQ-001 Parameters, each on its own line as name, default, meaning:
- BUFP_WIDTH, 3, buffer select bits; NBUF = 2**BUFP_WIDTH buffers.
- FIELDP_WIDTH, 5, field index bits; NFIELD = 2**FIELDP_WIDTH fields per buffer.
- BUFFER_WIDTH, 8, field data width.
REQ-002 clk, input, 1: single clock; all state changes on posedge.
REQ-003 reset, input, 1: synchronous, active-high.
REQ-004 bufp, input, BUFP_WIDTH: processor-selected buffer.
REQ-005 fieldp, input, FIELDP_WIDTH: processor read field index.
REQ-006 fieldwp, input, FIELDP_WIDTH: processor write field index.
REQ-007 write_en, input, 1: processor write strobe.
REQ-008 field_out, input, BUFFER_WIDTH: processor write data.
REQ-009 field_in, output, BUFFER_WIDTH: processor read data, combinational mem[bufp][fieldp].
REQ-010 proc_done, input, 1: processor releases buffer bufp.
REQ-011 buf_ready, output, 1: high while state[bufp]==FULL.
REQ-012 in_valid / in_ready / in_last, in/out/in, 1 each: fill stream handshake.
REQ-013 in_data, input, BUFFER_WIDTH: fill stream data.
REQ-014 out_valid / out_ready / out_last, out/in/out, 1 each: drain stream handshake.
REQ-015 out_data, output, BUFFER_WIDTH: drain stream data.

Function
REQ-016 Each buffer has a state: EMPTY, FILLING, FULL, DONE, DRAINING, plus a length len[b] in the range 1..NFIELD.
REQ-017 Fill pointer fill_buf and field index fill_idx; a transfer occurs when in_valid && in_ready.
- in_ready = state[fill_buf] is EMPTY or FILLING.
- Transfer writes mem[fill_buf][fill_idx]=in_data and moves an EMPTY buffer to FILLING.
REQ-018 A transfer with in_last, or with fill_idx==NFIELD-1, ends the fill:
- len = fill_idx+1; state goes to FULL.
- fill_idx goes to 0; fill_buf increments and wraps NBUF-1 to 0.
REQ-019 In any other transfer, fill_idx increments.
REQ-020 A write_en when state[bufp]==FULL writes field_out to mem[bufp][fieldwp]; in any other state the write is ignored.
REQ-021 A proc_done when state[bufp]==FULL moves that buffer to DONE; otherwise proc_done is ignored.
- If write_en occurs in the same cycle, the write completes first.
REQ-022 Drain pointer drain_buf and index drain_idx.
- out_valid is registered; it rises the cycle after state[drain_buf] becomes DONE, and the buffer becomes DRAINING.
- out_data = mem[drain_buf][drain_idx].
- out_last = (drain_idx == len-1).
REQ-023 On a handshake (out_valid && out_ready), drain_idx increments.
- On the last handshake: state goes to EMPTY, drain_idx goes to 0, drain_buf increments with wrap, and out_valid drops for at least 1 cycle.
REQ-024 While out_valid && !out_ready, out_data and out_last are held stable.
REQ-025 Buffers fill and drain strictly in index order; with all NBUF buffers FULL or later, in_ready=0.
REQ-026 Fill, processor write and drain target different buffers by construction, so all three may occur in the same cycle.

Reset
REQ-027 On reset:
- All states go to EMPTY; fill_buf, fill_idx, drain_buf, drain_idx go to 0; out_valid=0.
- in_ready=1 in the next cycle; buf_ready=0.
- A reset mid-fill or mid-drain discards the transfer.
REQ-028 Memory contents and len are not reset.

Configuration
REQ-029 Macro PATBUF_CLEAR_ON_DRAIN_EN:
- When defined, each drained field is written to 0 on its handshake.
- When undefined, memory is untouched by draining.

Verification
REQ-030 Fill buffer 0 with 4 bytes 0x11..0x44, last on 4th -> buffer 0 FULL, len=4, in_ready stays 1 for buffer 1, bufp=0 fieldp=2 gives field_in=0x33.
REQ-031 bufp=0, write_en, fieldwp=1, field_out=0xA5, then proc_done -> drain emits 0x11,0xA5,0x33,0x44 with out_last on 0x44; with PATBUF_CLEAR_ON_DRAIN_EN defined, a refill read-back before write shows 0x00 in unwritten fields.
REQ-032 Fill 32 bytes without in_last -> auto-terminate at 32, len=32, fill_buf advances.
REQ-033 Fill all 8 buffers -> in_ready=0; release and drain buffer 0 -> in_ready returns to 1 and fill_buf wraps to 0.
REQ-034 write_en and proc_done to an EMPTY buffer -> no memory change, no state change; out_ready held low 5 cycles -> out_data stable.
REQ-035 Assert reset mid-drain at drain_idx=2 -> next cycle out_valid=0, all EMPTY, in_ready=1, buf_ready=0.
